// File: rtl/bslu_pkg.sv
// bslu_pkg: shared opcodes, XOR macro states and default geometry for the bit-serial logic unit
package bslu_pkg;
    localparam int LANES_D = 8;
    localparam int NREGS_D = 4;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MOV   = 4'd1,
        OP_SET   = 4'd2,
        OP_NAND  = 4'd3,
        OP_LOAD  = 4'd4,
        OP_STORE = 4'd5,
        OP_XOR   = 4'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_X1   = 2'd1,
        ST_X2   = 2'd2,
        ST_X3   = 2'd3
    } xst_e;
endpackage

// File: rtl/bslu_regfile.sv
// bslu_regfile: NREGS x LANES register file, one write port, every register readable combinationally
module bslu_regfile
    import bslu_pkg::*;
#(
    parameter int LANES = LANES_D,
    parameter int NREGS = NREGS_D
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_we,
    input  logic [$clog2(NREGS)-1:0]    i_wa,
    input  logic [LANES-1:0]            i_wd,
    output logic [NREGS-1:0][LANES-1:0] o_r
);
    logic [NREGS-1:0][LANES-1:0] r_regs;

    // single write port; reset clears the whole array
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_regs <= '0;
        else if (i_we) r_regs[i_wa] <= i_wd;

    assign o_r = r_regs;
endmodule

// File: rtl/bslu_nand_vec.sv
// bslu_nand_vec: LANES-wide bit-serial logic unit with NAND/MOV/SET/LOAD/STORE and a 4-step NAND-based XOR macro
module bslu_nand_vec
    import bslu_pkg::*;
#(
    parameter int LANES = LANES_D,
    parameter int NREGS = NREGS_D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [NREGS-1:0]         cmd_mask,
    input  logic [$clog2(NREGS)-1:0] cmd_ra,
    input  logic [$clog2(NREGS)-1:0] cmd_rb,
    input  logic                     cmd_imm,
    input  logic [LANES-1:0]         row_in,
    output logic [LANES-1:0]         row_out,
    output logic                     row_we,
    output logic                     busy,
    output logic                     err
);
    localparam int AW = $clog2(NREGS);

    xst_e                        r_state, w_next;
    logic [NREGS-1:0][LANES-1:0] w_r;
    logic [LANES-1:0]            w_or, w_and, w_nand, w_wd;
    logic [LANES-1:0]            r_a, r_b, r_t1, r_t2;
    logic [AW-1:0]               r_xrd, w_wa;
    logic                        w_acc, w_we;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = !cmd_ready;
    assign w_acc     = cmd_valid && cmd_ready;

    // OR and AND reductions over the mask-selected registers
    always_comb begin
        w_or  = '0;
        w_and = '1;
        for (int i = 0; i < NREGS; i++)
            if (cmd_mask[i]) begin
                w_or  = w_or | w_r[i];
                w_and = w_and & w_r[i];
            end
    end

    assign w_nand = (|cmd_mask) ? ~w_and : '0;

    // one write port shared by single-cycle ops and the final XOR step (no accept can overlap X3)
    always_comb begin
        w_we = (w_acc && (cmd_op == OP_MOV || cmd_op == OP_SET || cmd_op == OP_NAND || cmd_op == OP_LOAD))
               || r_state == ST_X3;
        w_wa = (r_state == ST_X3) ? r_xrd : (cmd_op == OP_LOAD) ? '0 : cmd_rd;
        w_wd = (r_state == ST_X3)  ? ~(r_t2 & r_t1) :
               (cmd_op == OP_MOV)  ? w_or :
               (cmd_op == OP_SET)  ? {LANES{cmd_imm}} :
               (cmd_op == OP_NAND) ? w_nand : row_in;
    end

    bslu_regfile #(.LANES(LANES), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (w_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .o_r   (w_r)
    );

    // XOR macro state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= ST_IDLE;
        else r_state <= w_next;

    // XOR macro sequencing: leaves IDLE only on an accepted XOR, then walks X1..X3 unconditionally
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = (w_acc && cmd_op == OP_XOR) ? ST_X1 : ST_IDLE;
            ST_X1:   w_next = ST_X2;
            ST_X2:   w_next = ST_X3;
            default: w_next = ST_IDLE;
        endcase
    end

    // operand capture and the three NAND steps that build t1/t2 before the X3 write
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_t1  <= '0;
            r_t2  <= '0;
            r_xrd <= '0;
        end else if (w_acc && cmd_op == OP_XOR) begin
            r_a   <= w_r[cmd_ra];
            r_b   <= w_r[cmd_rb];
            r_t1  <= ~(w_r[cmd_ra] & w_r[cmd_rb]);
            r_xrd <= cmd_rd;
        end else if (r_state == ST_X1) r_t2 <= ~(r_a & r_t1);
        else if (r_state == ST_X2) r_t1 <= ~(r_b & r_t1);

    // write-back port: one-cycle strobe, data held between stores
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            row_out <= '0;
            row_we  <= 1'b0;
        end else begin
            row_we <= w_acc && cmd_op == OP_STORE;
            if (w_acc && cmd_op == OP_STORE) row_out <= w_r[cmd_ra];
        end

    // sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err <= 1'b0;
        else if (w_acc && cmd_op > OP_XOR) err <= 1'b1;
endmodule

// File: tb/tb_bslu_nand_vec.sv
// tb_bslu_nand_vec: table-driven plus hand-sequenced checks of bslu_nand_vec (LANES=8, NREGS=4)
module tb_bslu_nand_vec;
    logic       clk, rst_n, cmd_valid, cmd_ready, cmd_imm, row_we, busy, err;
    logic [3:0] cmd_op, cmd_mask;
    logic [1:0] cmd_rd, cmd_ra, cmd_rb;
    logic [7:0] row_in, row_out;
    int         checks = 0;
    int         errors = 0;

    bslu_nand_vec #(.LANES(8), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_mask(cmd_mask), .cmd_ra(cmd_ra),
        .cmd_rb(cmd_rb), .cmd_imm(cmd_imm), .row_in(row_in), .row_out(row_out),
        .row_we(row_we), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [3:0] mask;
        logic       imm;
        logic [7:0] row;
        logic [1:0] chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [3:0] mask,
                         input logic [1:0] ra, input logic [1:0] rb, input logic imm,
                         input logic [7:0] row);
        cmd_op = op; cmd_rd = rd; cmd_mask = mask; cmd_ra = ra; cmd_rb = rb;
        cmd_imm = imm; row_in = row; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rdreg(input logic [1:0] idx, output logic [7:0] v);
        issue(4'd5, 2'd0, 4'd0, idx, 2'd0, 1'b0, 8'h00);
        v = row_out;
    endtask

    task automatic chkreg(input string name, input logic [1:0] idx, input logic [7:0] exp);
        logic [7:0] v;
        rdreg(idx, v);
        chk(name, {24'd0, v}, {24'd0, exp});
    endtask

    task automatic xor_wait(input string name);
        int n = 0;
        while (!cmd_ready && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk(name, n, 3);
    endtask

    initial begin
        logic [7:0] v;
        vt[0]  = '{4'd4, 2'd3, 4'b0000, 1'b0, 8'hA5, 2'd0, 8'hA5};
        vt[1]  = '{4'd1, 2'd1, 4'b0001, 1'b0, 8'h00, 2'd1, 8'hA5};
        vt[2]  = '{4'd0, 2'd0, 4'b0000, 1'b0, 8'h00, 2'd3, 8'h00};
        vt[3]  = '{4'd4, 2'd0, 4'b0000, 1'b0, 8'hF0, 2'd0, 8'hF0};
        vt[4]  = '{4'd1, 2'd1, 4'b0001, 1'b0, 8'h00, 2'd1, 8'hF0};
        vt[5]  = '{4'd4, 2'd0, 4'b0000, 1'b0, 8'h3C, 2'd0, 8'h3C};
        vt[6]  = '{4'd1, 2'd2, 4'b0001, 1'b0, 8'h00, 2'd2, 8'h3C};
        vt[7]  = '{4'd3, 2'd3, 4'b0110, 1'b0, 8'h00, 2'd3, 8'hCF};
        vt[8]  = '{4'd3, 2'd3, 4'b0000, 1'b0, 8'h00, 2'd3, 8'h00};
        vt[9]  = '{4'd1, 2'd3, 4'b0110, 1'b0, 8'h00, 2'd3, 8'hFC};
        vt[10] = '{4'd1, 2'd3, 4'b0000, 1'b0, 8'h00, 2'd3, 8'h00};
        vt[11] = '{4'd3, 2'd0, 4'b0111, 1'b0, 8'h00, 2'd0, 8'hCF};
        vt[12] = '{4'd2, 2'd3, 4'b0000, 1'b1, 8'h00, 2'd3, 8'hFF};
        vt[13] = '{4'd3, 2'd3, 4'b1111, 1'b0, 8'h00, 2'd3, 8'hFF};
        vt[14] = '{4'd1, 2'd0, 4'b1110, 1'b0, 8'h00, 2'd0, 8'hFF};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_mask = '0;
        cmd_ra = '0; cmd_rb = '0; cmd_imm = 1'b0; row_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_row_we", {31'd0, row_we}, 0);
        chk("rst_row_out", {24'd0, row_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            issue(vt[i].op, vt[i].rd, vt[i].mask, 2'd0, 2'd0, vt[i].imm, vt[i].row);
            chk("vec_ready", {31'd0, cmd_ready}, 1);
            rdreg(vt[i].chk, v);
            chk($sformatf("vec%0d", i), {24'd0, v}, {24'd0, vt[i].exp});
            chk($sformatf("vec%0d_we", i), {31'd0, row_we}, 1);
        end

        issue(4'd6, 2'd1, 4'd0, 2'd1, 2'd2, 1'b0, 8'h00);
        chk("xor_busy", {31'd0, busy}, 1);
        xor_wait("xor_ready_low_cycles");
        chk("xor_busy_after", {31'd0, busy}, 0);
        chkreg("xor_r1", 2'd1, 8'hCC);
        chkreg("xor_r2_kept", 2'd2, 8'h3C);

        issue(4'd6, 2'd3, 4'd0, 2'd2, 2'd2, 1'b0, 8'h00);
        xor_wait("xor_same_cycles");
        chkreg("xor_same_zero", 2'd3, 8'h00);

        issue(4'd6, 2'd2, 4'd0, 2'd1, 2'd0, 1'b0, 8'h00);
        xor_wait("xor_r1r0_cycles");
        chkreg("xor_r1r0", 2'd2, 8'h33);

        issue(4'd2, 2'd2, 4'd0, 2'd0, 2'd0, 1'b1, 8'h00);
        issue(4'd5, 2'd0, 4'd0, 2'd2, 2'd0, 1'b0, 8'h00);
        chk("store_row_out", {24'd0, row_out}, 32'hFF);
        chk("store_we_hi", {31'd0, row_we}, 1);
        @(posedge clk);
        #1;
        chk("store_we_lo", {31'd0, row_we}, 0);
        chk("store_hold", {24'd0, row_out}, 32'hFF);

        chk("err_before", {31'd0, err}, 0);
        issue(4'd9, 2'd0, 4'b1111, 2'd1, 2'd2, 1'b1, 8'h11);
        chk("err_set", {31'd0, err}, 1);
        chk("ill_ready", {31'd0, cmd_ready}, 1);
        chkreg("ill_r0", 2'd0, 8'hFF);
        chkreg("ill_r1", 2'd1, 8'hCC);
        chkreg("ill_r2", 2'd2, 8'hFF);
        chkreg("ill_r3", 2'd3, 8'h00);
        issue(4'd0, 2'd0, 4'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        chk("err_sticky", {31'd0, err}, 1);

        issue(4'd6, 2'd1, 4'd0, 2'd1, 2'd0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk("x2_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_ready", {31'd0, cmd_ready}, 1);
        chk("arst_err", {31'd0, err}, 0);
        chk("arst_row_out", {24'd0, row_out}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd2, 2'd3, 4'd0, 2'd0, 2'd0, 1'b1, 8'h00);
        chkreg("post_rst_first_accept", 2'd3, 8'hFF);
        chkreg("post_rst_r0", 2'd0, 8'h00);
        chkreg("post_rst_r1", 2'd1, 8'h00);
        chkreg("post_rst_r2", 2'd2, 8'h00);
        chk("post_rst_err", {31'd0, err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bslu_nand_vec.md
BSLU_NAND_VEC -- requirements
Module: bslu_nand_vec

Interface
REQ-001 SHALL have parameter LANES, default 8, the number of bit-serial lanes (columns) processed in parallel.
REQ-002 SHALL have parameter NREGS, default 4 (power of 2, >=2), the number of LANES-wide registers; r0 is the sense-amp register SA.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, command present.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 SHALL have port cmd_op, input, 4, the opcode: 0 NOP, 1 MOV, 2 SET, 3 NAND, 4 LOAD, 5 STORE, 6 XOR; 7-15 illegal.
REQ-008 SHALL have port cmd_rd, input, log2(NREGS), the destination register index.
REQ-009 SHALL have port cmd_mask, input, NREGS, the source-register select mask for MOV and NAND.
REQ-010 SHALL have ports cmd_ra and cmd_rb, input, log2(NREGS) each, the source indices for XOR and STORE (STORE uses ra only).
REQ-011 SHALL have port cmd_imm, input, 1, the SET value.
REQ-012 SHALL have port row_in, input, LANES, the row data sensed from the array.
REQ-013 SHALL have port row_out, output, LANES, the write-back data.
REQ-014 SHALL have port row_we, output, 1, a one-cycle write-back strobe.
REQ-015 SHALL have port busy, output, 1, high while an XOR macro is in progress.
REQ-016 SHALL have port err, output, 1, the sticky illegal-opcode flag.

Function
REQ-017 MOV: rd <= bitwise OR of r[i] over all set bits of cmd_mask; an empty mask writes all zeros.
REQ-018 NAND: rd <= ~(bitwise AND of r[i] over all set bits of cmd_mask); an empty mask writes all zeros (the AND of an empty set is all ones).
REQ-019 SET: rd <= {LANES{cmd_imm}}.
REQ-020 LOAD: r0 <= row_in; cmd_rd is ignored.
REQ-021 STORE: row_out <= r[ra] and row_we = 1 for the cycle after acceptance; otherwise row_we = 0 and row_out holds its last value.
REQ-022 Single-cycle ops (NOP, MOV, SET, NAND, LOAD, STORE) SHALL update state on the accepting edge; all sources are read as pre-edge values; cmd_ready stays high.
REQ-023 XOR SHALL compute rd <= r[ra] ^ r[rb] as four NAND steps using two hidden LANES-wide temporaries t1 and t2.
REQ-024 XOR FSM: IDLE -(accept XOR)-> X1 -> X2 -> X3 -> IDLE; one transition per cycle, unconditional.
REQ-025 XOR steps: accept edge t1 = nand(a,b); X1 edge t2 = nand(a,t1); X2 edge t1 = nand(b,t1); X3 edge rd = nand(t2,t1).
REQ-026 The XOR operands a, b and the index rd SHALL be captured at acceptance; register changes during the macro are impossible because no command is accepted.
REQ-027 cmd_ready = (state == IDLE); busy = (state != IDLE); the result latency of XOR is 4 edges from acceptance, and back-to-back XORs are spaced 4 cycles apart.
REQ-028 Architectural registers r0..r(NREGS-1) SHALL be unmodified by XOR until the X3 edge.
REQ-029 Ra == rb in XOR SHALL yield all zeros; rd equal to ra or rb is legal.
REQ-030 Illegal opcodes SHALL be accepted, behave as NOP, and set err; err clears only on reset.

Reset
REQ-031 While rst_n is low, all r[i], t1, t2 and row_out SHALL be 0, row_we = 0, err = 0, and state = IDLE, asynchronously.
REQ-032 Reset asserted mid-XOR SHALL abort the macro with no rd write; the first accept is possible on the first edge after deassertion.

Structure
REQ-033 Shared package bslu_pkg SHALL hold the opcode enum, the XOR FSM state enum and the default LANES/NREGS constants.
REQ-034 A sub-module bslu_regfile (NREGS x LANES, one write port, all registers readable combinationally) SHALL hold r0..r(NREGS-1).

Verification (LANES=8, NREGS=4)
REQ-035 LOAD with row_in=0xA5, then MOV rd=1 mask=0001 -> r1 = 0xA5.
REQ-036 r1=0xF0, r2=0x3C; NAND rd=3 mask=0110 -> r3 = 0xCF; NAND with mask=0000 -> rd = 0x00.
REQ-037 r1=0xF0, r2=0x3C; XOR rd=1 ra=1 rb=2 -> cmd_ready low 3 cycles, r1 = 0xCC on the 4th edge, busy low thereafter.
REQ-038 SET rd=2 imm=1, then STORE ra=2 -> row_out = 0xFF and row_we high for exactly 1 cycle.
REQ-039 Opcode 9 -> err = 1 and no register changes; rst_n pulsed low during X2 -> all registers 0, state IDLE, err = 0.
